// File: rtl/sopc_run_ctrl.sv
// Run controller for a small SoC core: staggered per-domain reset release,
// a bounded run window, then a frozen DONE state until a restart is requested.
module sopc_run_ctrl #(
  parameter int N_RST      = 2,
  parameter int RST_CYCLES = 10,
  parameter int STAGGER    = 1,
  parameter int RUN_CYCLES = 500,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_i,
  output logic [N_RST-1:0] core_rst_n_o,
  output logic             running_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [1:0]       state_o
);

  // Last hold count: the cycle that releases the final domain.
  localparam int HMAX = RST_CYCLES - 1 + (N_RST - 1) * STAGGER;
  localparam int HW   = (HMAX < 1) ? 1 : $clog2(HMAX + 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    h_q, h_d;
  logic [N_RST-1:0] core_rst_n_q, core_rst_n_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    core_rst_n_d = core_rst_n_q;
    running_d    = running_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    cnt_d        = cnt_q;

    if (start) begin
      // Restart outranks halt and timeout in every state.
      state_d      = S_HOLD;
      h_d          = '0;
      core_rst_n_d = '0;
      running_d    = 1'b0;
      done_d       = 1'b0;
      timeout_d    = 1'b0;
      cnt_d        = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          h_d = h_q + HW'(1);
          for (int k = 0; k < N_RST; k++) begin
            if (int'(h_q) == RST_CYCLES - 1 + k * STAGGER) core_rst_n_d[k] = 1'b1;
          end
          if (int'(h_q) >= HMAX) begin
            state_d   = S_RUN;
            running_d = 1'b1;
            h_d       = '0;
          end
        end
        S_RUN: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (halt_i) begin
            state_d      = S_DONE;
            running_d    = 1'b0;
            done_d       = 1'b1;
            timeout_d    = 1'b0;
            core_rst_n_d = '0;
          end else if ((RUN_CYCLES != 0) && (cnt_q == RUN_LAST)) begin
            state_d      = S_DONE;
            running_d    = 1'b0;
            done_d       = 1'b1;
            timeout_d    = 1'b1;
            core_rst_n_d = '0;
          end
        end
        S_DONE: begin
          core_rst_n_d = '0;
        end
        default: begin
          state_d      = S_HOLD;
          h_d          = '0;
          core_rst_n_d = '0;
          running_d    = 1'b0;
          done_d       = 1'b0;
          timeout_d    = 1'b0;
          cnt_d        = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_HOLD;
      h_q          <= '0;
      core_rst_n_q <= '0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      core_rst_n_q <= core_rst_n_d;
      running_q    <= running_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  assign core_rst_n_o = core_rst_n_q;
  assign running_o    = running_q;
  assign done_o       = done_q;
  assign timeout_o    = timeout_q;
  assign cycle_cnt_o  = cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Directed bench for sopc_run_ctrl: default build, a 4-domain staggered build
// and a narrow free-running counter build, all sharing one clock and inputs.
module tb_sopc_run_ctrl;

  logic clk;
  logic rst_n;
  logic start;
  logic halt;

  int vectors;
  int miscompares;

  // Instance A: defaults.
  logic [1:0]  a_core;
  logic        a_run, a_done, a_to;
  logic [31:0] a_cnt;
  logic [1:0]  a_state;

  // Instance B: N_RST=4, RST_CYCLES=5, STAGGER=3, RUN_CYCLES=4.
  logic [3:0]  b_core;
  logic        b_run, b_done, b_to;
  logic [31:0] b_cnt;
  logic [1:0]  b_state;

  // Instance C: one domain, immediate release, unlimited run, 4-bit counter.
  logic [0:0]  c_core;
  logic        c_run, c_done, c_to;
  logic [3:0]  c_cnt;
  logic [1:0]  c_state;

  sopc_run_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_i(halt),
    .core_rst_n_o(a_core), .running_o(a_run), .done_o(a_done),
    .timeout_o(a_to), .cycle_cnt_o(a_cnt), .state_o(a_state)
  );

  sopc_run_ctrl #(.N_RST(4), .RST_CYCLES(5), .STAGGER(3), .RUN_CYCLES(4), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_i(halt),
    .core_rst_n_o(b_core), .running_o(b_run), .done_o(b_done),
    .timeout_o(b_to), .cycle_cnt_o(b_cnt), .state_o(b_state)
  );

  sopc_run_ctrl #(.N_RST(1), .RST_CYCLES(1), .STAGGER(0), .RUN_CYCLES(0), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_i(halt),
    .core_rst_n_o(c_core), .running_o(c_run), .done_o(c_done),
    .timeout_o(c_to), .cycle_cnt_o(c_cnt), .state_o(c_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ten cycles of reset; leaves rst_n low so the caller can inspect reset values.
  task automatic hold_reset();
    rst_n = 1'b0;
    start = 1'b0;
    halt  = 1'b0;
    tick(10);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    hold_reset();
    vectors++;
    if ({a_core, a_run, a_done, a_to, a_state} !== {2'b00, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      $display("FAIL reset_a_flags: got %b want %b", {a_core, a_run, a_done, a_to, a_state}, 7'b0);
      miscompares++;
    end
    vectors++;
    if (a_cnt !== 32'd0) begin
      $display("FAIL reset_a_cnt: got %0d want 0", a_cnt);
      miscompares++;
    end
    vectors++;
    if ({b_core, b_run, b_done, b_to, c_core, c_run, c_cnt} !== 14'b0) begin
      $display("FAIL reset_bc: got %b want 0", {b_core, b_run, b_done, b_to, c_core, c_run, c_cnt});
      miscompares++;
    end
  endtask

  // Default release: [0] after 10 edges, [1] and running after 11.
  task automatic check_a_release(input string tag);
    tick(9);
    vectors++;
    if ({a_core, a_run} !== {2'b00, 1'b0}) begin
      $display("FAIL %s_e9: got core=%b run=%b want core=00 run=0", tag, a_core, a_run);
      miscompares++;
    end
    tick(1);
    vectors++;
    if ({a_core, a_run} !== {2'b01, 1'b0}) begin
      $display("FAIL %s_e10: got core=%b run=%b want core=01 run=0", tag, a_core, a_run);
      miscompares++;
    end
    tick(1);
    vectors++;
    if ({a_core, a_run, a_done, a_cnt} !== {2'b11, 1'b1, 1'b0, 32'd0}) begin
      $display("FAIL %s_e11: got core=%b run=%b done=%b cnt=%0d want core=11 run=1 done=0 cnt=0",
               tag, a_core, a_run, a_done, a_cnt);
      miscompares++;
    end
  endtask

  task automatic test_release();
    rst_n = 1'b1;
    check_a_release("release");
  endtask

  task automatic test_timeout();
    tick(499);
    vectors++;
    if ({a_run, a_done, a_cnt} !== {1'b1, 1'b0, 32'd499}) begin
      $display("FAIL timeout_pre: got run=%b done=%b cnt=%0d want run=1 done=0 cnt=499", a_run, a_done, a_cnt);
      miscompares++;
    end
    tick(1);
    vectors++;
    if ({a_core, a_run, a_done, a_to, a_cnt, a_state} !== {2'b00, 1'b0, 1'b1, 1'b1, 32'd500, 2'd2}) begin
      $display("FAIL timeout_end: got core=%b run=%b done=%b to=%b cnt=%0d want core=00 run=0 done=1 to=1 cnt=500",
               a_core, a_run, a_done, a_to, a_cnt);
      miscompares++;
    end
    tick(3);
    vectors++;
    if ({a_done, a_to, a_cnt} !== {1'b1, 1'b1, 32'd500}) begin
      $display("FAIL timeout_hold: got done=%b to=%b cnt=%0d want done=1 to=1 cnt=500", a_done, a_to, a_cnt);
      miscompares++;
    end
  endtask

  task automatic test_start_from_done();
    pulse_start();
    vectors++;
    if ({a_core, a_run, a_done, a_to, a_cnt, a_state} !== {2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0}) begin
      $display("FAIL restart_hold: got core=%b run=%b done=%b to=%b cnt=%0d want all zero",
               a_core, a_run, a_done, a_to, a_cnt);
      miscompares++;
    end
    check_a_release("restart");
  endtask

  task automatic test_halt_37();
    tick(37);
    vectors++;
    if (a_cnt !== 32'd37) begin
      $display("FAIL halt37_pre: got cnt=%0d want 37", a_cnt);
      miscompares++;
    end
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    vectors++;
    if ({a_core, a_run, a_done, a_to, a_cnt} !== {2'b00, 1'b0, 1'b1, 1'b0, 32'd38}) begin
      $display("FAIL halt37_end: got core=%b run=%b done=%b to=%b cnt=%0d want core=00 run=0 done=1 to=0 cnt=38",
               a_core, a_run, a_done, a_to, a_cnt);
      miscompares++;
    end
    halt = 1'b1;
    tick(3);
    halt = 1'b0;
    vectors++;
    if ({a_done, a_to, a_cnt, a_state} !== {1'b1, 1'b0, 32'd38, 2'd2}) begin
      $display("FAIL halt_in_done: got done=%b to=%b cnt=%0d state=%0d want done=1 to=0 cnt=38 state=2",
               a_done, a_to, a_cnt, a_state);
      miscompares++;
    end
  endtask

  task automatic test_halt_at_limit();
    pulse_start();
    tick(11 + 499);
    vectors++;
    if ({a_run, a_cnt} !== {1'b1, 32'd499}) begin
      $display("FAIL halt499_pre: got run=%b cnt=%0d want run=1 cnt=499", a_run, a_cnt);
      miscompares++;
    end
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    vectors++;
    if ({a_done, a_to, a_cnt} !== {1'b1, 1'b0, 32'd500}) begin
      $display("FAIL halt499_end: got done=%b to=%b cnt=%0d want done=1 to=0 cnt=500", a_done, a_to, a_cnt);
      miscompares++;
    end
  endtask

  task automatic test_start_over_halt();
    pulse_start();
    tick(11 + 5);
    vectors++;
    if ({a_run, a_cnt} !== {1'b1, 32'd5}) begin
      $display("FAIL start_halt_pre: got run=%b cnt=%0d want run=1 cnt=5", a_run, a_cnt);
      miscompares++;
    end
    start = 1'b1;
    halt  = 1'b1;
    tick(1);
    start = 1'b0;
    halt  = 1'b0;
    vectors++;
    if ({a_core, a_run, a_done, a_to, a_cnt, a_state} !== {2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0}) begin
      $display("FAIL start_halt: got core=%b run=%b done=%b to=%b cnt=%0d state=%0d want HOLD all zero",
               a_core, a_run, a_done, a_to, a_cnt, a_state);
      miscompares++;
    end
  endtask

  // Edge-by-edge expected B outputs for edges 1..14 after release.
  task automatic check_b_seq(input string tag);
    logic [3:0] exp_core [1:14];
    logic       exp_run  [1:14];
    exp_core = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
                 4'b0011, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b0111, 4'b1111};
    exp_run  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int t = 1; t <= 14; t++) begin
      tick(1);
      vectors++;
      if ({b_core, b_run, b_done} !== {exp_core[t], exp_run[t], 1'b0}) begin
        $display("FAIL %s_e%0d: got core=%b run=%b done=%b want core=%b run=%b done=0",
                 tag, t, b_core, b_run, b_done, exp_core[t], exp_run[t]);
        miscompares++;
      end
    end
    tick(4);
    vectors++;
    if ({b_core, b_run, b_done, b_to, b_cnt} !== {4'b0000, 1'b0, 1'b1, 1'b1, 32'd4}) begin
      $display("FAIL %s_done: got core=%b run=%b done=%b to=%b cnt=%0d want core=0000 run=0 done=1 to=1 cnt=4",
               tag, b_core, b_run, b_done, b_to, b_cnt);
      miscompares++;
    end
  endtask

  task automatic test_stagger();
    hold_reset();
    rst_n = 1'b1;
    check_b_seq("stagger");
    pulse_start();
    vectors++;
    if ({b_core, b_done, b_cnt} !== {4'b0000, 1'b0, 32'd0}) begin
      $display("FAIL stagger_restart: got core=%b done=%b cnt=%0d want core=0000 done=0 cnt=0", b_core, b_done, b_cnt);
      miscompares++;
    end
    check_b_seq("stagger_rep");
  endtask

  task automatic test_wrap();
    hold_reset();
    rst_n = 1'b1;
    tick(1);
    vectors++;
    if ({c_core, c_run, c_cnt} !== {1'b1, 1'b1, 4'd0}) begin
      $display("FAIL wrap_start: got core=%b run=%b cnt=%0d want core=1 run=1 cnt=0", c_core, c_run, c_cnt);
      miscompares++;
    end
    tick(15);
    vectors++;
    if (c_cnt !== 4'd15) begin
      $display("FAIL wrap_pre: got cnt=%0d want 15", c_cnt);
      miscompares++;
    end
    tick(1);
    vectors++;
    if ({c_run, c_done, c_to, c_cnt} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      $display("FAIL wrap: got run=%b done=%b to=%b cnt=%0d want run=1 done=0 to=0 cnt=0",
               c_run, c_done, c_to, c_cnt);
      miscompares++;
    end
  endtask

  task automatic test_reset_midrun();
    hold_reset();
    rst_n = 1'b1;
    tick(11 + 20);
    vectors++;
    if ({a_run, a_cnt} !== {1'b1, 32'd20}) begin
      $display("FAIL midrun_pre: got run=%b cnt=%0d want run=1 cnt=20", a_run, a_cnt);
      miscompares++;
    end
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    vectors++;
    if ({a_core, a_run, a_done, a_to, a_cnt, a_state} !== {2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0}) begin
      $display("FAIL midrun_reset: got core=%b run=%b done=%b to=%b cnt=%0d want all zero",
               a_core, a_run, a_done, a_to, a_cnt);
      miscompares++;
    end
    check_a_release("midrun");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    halt  = 1'b0;
    test_reset();
    test_release();
    test_timeout();
    test_start_from_done();
    test_halt_37();
    test_halt_at_limit();
    test_start_over_halt();
    test_stagger();
    test_wrap();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sopc_run_ctrl.md
SOPC_RUN_CTRL -- requirements
Module: sopc_run_ctrl

Interface
REQ-001 SHALL have parameter N_RST, default 2: number of core reset domains, minimum 1.
REQ-002 SHALL have parameter RST_CYCLES, default 10: cycles domain 0 is held in reset after rst_n release, minimum 1.
REQ-003 SHALL have parameter STAGGER, default 1: extra hold cycles between release of domain k and domain k+1, 0 allowed.
REQ-004 SHALL have parameter RUN_CYCLES, default 500: run-length limit in cycles; 0 means no limit.
REQ-005 SHALL have parameter CNT_W, default 32: width of the run cycle counter.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 start  input  1  restart request, sampled each cycle.
REQ-009 halt_i  input  1  core halt indication, ends a run early.
REQ-010 core_rst_n_o  output  N_RST  per-domain core reset, active-low, registered.
REQ-011 running_o  output  1  high while in RUN.
REQ-012 done_o  output  1  high while in DONE.
REQ-013 timeout_o  output  1  run ended by RUN_CYCLES limit, valid while done_o=1.
REQ-014 cycle_cnt_o  output  CNT_W  completed RUN cycles of current or last run.

Function
REQ-015 SHALL implement a three-state FSM: HOLD, RUN, DONE.
REQ-016 HOLD: hold counter h, 0 in the first HOLD cycle, +1 per cycle; core_rst_n_o[k] SHALL go 1 on the edge ending the HOLD cycle where h == RST_CYCLES-1 + k*STAGGER, and stay 1 for the rest of HOLD.
REQ-017 HOLD->RUN SHALL occur on the same edge that releases domain N_RST-1; running_o=1 from the following cycle.
REQ-018 RUN: all core_rst_n_o bits 1; cycle_cnt_o SHALL increment by 1 on every RUN-cycle edge, including the exit edge.
REQ-019 RUN->DONE with timeout_o=0 SHALL occur on the edge ending a RUN cycle with halt_i=1.
REQ-020 RUN->DONE with timeout_o=1 SHALL occur when RUN_CYCLES!=0, cycle_cnt_o==RUN_CYCLES-1 and halt_i=0; cycle_cnt_o then reads RUN_CYCLES.
REQ-021 halt_i and timeout condition in the same cycle: halt wins, timeout_o=0.
REQ-022 DONE: all core_rst_n_o bits 0 (core frozen); cycle_cnt_o and timeout_o hold; done_o=1.
REQ-023 start=1 in any state SHALL move to HOLD on the next edge with h=0, all core_rst_n_o=0, cycle_cnt_o=0, timeout_o=0; start has priority over halt_i and timeout.
REQ-024 halt_i SHALL be ignored outside RUN.
REQ-025 cycle_cnt_o SHALL wrap modulo 2^CNT_W when RUN_CYCLES=0; no flag on wrap.
REQ-026 Hold counter SHALL be wide enough for RST_CYCLES-1 + (N_RST-1)*STAGGER without overflow.
REQ-027 running_o and done_o SHALL be mutually exclusive; both 0 in HOLD.

Reset
REQ-028 rst_n=0 on a rising edge SHALL force state HOLD, h=0, core_rst_n_o=all 0, running_o=0, done_o=0, timeout_o=0, cycle_cnt_o=0, regardless of state.
REQ-029 Reset asserted mid-RUN or mid-HOLD SHALL discard progress; the hold sequence SHALL restart from h=0 on the first edge with rst_n=1.
REQ-030 Outputs SHALL never glitch: all driven directly from flops.

Verification
REQ-031 Defaults, rst_n low 10 cycles then high -> core_rst_n_o[0]=1 after 10 cycles, [1]=1 one cycle later, running_o=1 in same cycle as [1].
REQ-032 Defaults, no halt -> after 500 RUN cycles done_o=1, timeout_o=1, cycle_cnt_o=500, core_rst_n_o=2'b00.
REQ-033 Defaults, halt_i pulse in RUN cycle with cycle_cnt_o=37 -> done_o=1, timeout_o=0, cycle_cnt_o=38.
REQ-034 halt_i=1 exactly when cycle_cnt_o=499 -> timeout_o=0, cycle_cnt_o=500; start=1 with halt_i=1 in RUN -> HOLD, cycle_cnt_o=0.
REQ-035 N_RST=4, STAGGER=3, RST_CYCLES=5 -> releases at 5, 8, 11, 14 cycles after rst_n high; start pulse in DONE -> same sequence repeats from 0.
REQ-036 rst_n dropped for 1 cycle mid-RUN -> next cycle all outputs at reset values, hold sequence restarts.
